// File: rtl/quad_mixer.sv
// Quadrature down-mixer: multiplies the receive sample by the DDS cosine/sine
// samples and delivers rounded, saturated I/Q products with a fixed 3-clock latency.
module quad_mixer #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  signal_in,
  input  logic signed [IN_W-1:0]  dds_i,
  input  logic signed [IN_W-1:0]  dds_q,
  output logic signed [OUT_W-1:0] mixed_signal_i,
  output logic signed [OUT_W-1:0] mixed_signal_q,
  output logic                    out_valid
);

  // Handshake: valid-only, no ready. A stage's data registers load only when the
  // valid entering that stage is high; the valid bits themselves advance every clock.

  localparam int P_W = 2 * IN_W;
  localparam int SH  = P_W - 1 - OUT_W;

  localparam logic [P_W:0]        RND   = (P_W + 1)'(64'd1 << SH) >> 1;
  localparam logic signed [P_W:0] MAX_V = $signed({{(P_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}});
  localparam logic signed [P_W:0] MIN_V = $signed({{(P_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}});

  // One extra bit keeps the half-up rounding addition from wrapping.
  function automatic logic signed [OUT_W-1:0] round_sat(input logic signed [P_W-1:0] p);
    logic signed [P_W:0] s;
    logic signed [P_W:0] r;
    s = $signed({p[P_W-1], p}) + $signed(RND);
    r = s >>> SH;
    if (r > MAX_V) begin
      round_sat = MAX_V[OUT_W-1:0];
    end else if (r < MIN_V) begin
      round_sat = MIN_V[OUT_W-1:0];
    end else begin
      round_sat = r[OUT_W-1:0];
    end
  endfunction

  logic                   s1_valid;
  logic signed [IN_W-1:0] s1_sig;
  logic signed [IN_W-1:0] s1_di;
  logic signed [IN_W-1:0] s1_dq;

  logic                   s2_valid;
  logic signed [P_W-1:0]  s2_pi;
  logic signed [P_W-1:0]  s2_pq;

  logic signed [P_W-1:0]  prod_i;
  logic signed [P_W-1:0]  prod_q;
  logic signed [OUT_W-1:0] res_i;
  logic signed [OUT_W-1:0] res_q;

  // Operands widened first so the multiply is done at full product width.
  assign prod_i = P_W'(s1_sig) * P_W'(s1_di);
  assign prod_q = P_W'(s1_sig) * P_W'(s1_dq);

  always_comb begin
    res_i = round_sat(s2_pi);
    res_q = round_sat(s2_pq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sig         <= '0;
      s1_di          <= '0;
      s1_dq          <= '0;
      s2_pi          <= '0;
      s2_pq          <= '0;
      mixed_signal_i <= '0;
      mixed_signal_q <= '0;
    end else begin
      if (in_valid) begin
        s1_sig <= signal_in;
        s1_di  <= dds_i;
        s1_dq  <= dds_q;
      end
      if (s1_valid) begin
        s2_pi <= prod_i;
        s2_pq <= prod_q;
      end
      if (s2_valid) begin
        mixed_signal_i <= res_i;
        mixed_signal_q <= res_q;
      end
    end
  end

endmodule

// File: tb/tb_quad_mixer.sv
// Directed and short random checks of quad_mixer: reset, latency, extremes,
// rounding, valid gaps, and asynchronous reset while samples are in flight.
module tb_quad_mixer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] signal_in;
  logic [15:0] dds_i;
  logic [15:0] dds_q;
  logic [23:0] mixed_signal_i;
  logic [23:0] mixed_signal_q;
  logic        out_valid;

  int total = 0;
  int bad   = 0;

  // Expected output stream, one entry per clock: {valid, i, q}.
  logic [48:0] exp_q[$];
  logic [23:0] hold_i;
  logic [23:0] hold_q;

  quad_mixer #(.IN_W(16), .OUT_W(24)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .signal_in      (signal_in),
    .dds_i          (dds_i),
    .dds_q          (dds_q),
    .mixed_signal_i (mixed_signal_i),
    .mixed_signal_q (mixed_signal_q),
    .out_valid      (out_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: full product, half-up rounding by 7 bits, clamp to 24-bit signed.
  function automatic logic [23:0] ref_mix(input logic [15:0] a, input logic [15:0] b);
    longint p;
    longint r;
    p = longint'($signed(a)) * longint'($signed(b));
    r = (p + 64) >>> 7;
    if (r > 64'sd8388607) r = 64'sd8388607;
    if (r < -64'sd8388608) r = -64'sd8388608;
    return r[23:0];
  endfunction

  // After reset the first two checked clocks precede any possible result.
  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(49'd0);
    exp_q.push_back(49'd0);
    hold_i = '0;
    hold_q = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_i"}, 64'(mixed_signal_i), 64'd0);
    check({tag, "_q"}, 64'(mixed_signal_q), 64'd0);
  endtask

  // driver: present one sample for one clock, then compare against the model
  task automatic step(input logic v, input logic [15:0] s, input logic [15:0] di,
                      input logic [15:0] dq, input logic [23:0] ei, input logic [23:0] eq);
    logic [48:0] e;
    in_valid  = v;
    signal_in = s;
    dds_i     = di;
    dds_q     = dq;
    exp_q.push_back({v, ei, eq});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    if (e[48]) begin
      hold_i = e[47:24];
      hold_q = e[23:0];
    end
    check("out_valid", 64'(out_valid), 64'(e[48]));
    check("mixed_i", 64'(mixed_signal_i), 64'(hold_i));
    check("mixed_q", 64'(mixed_signal_q), 64'(hold_q));
  endtask

  task automatic step_ref(input logic v, input logic [15:0] s, input logic [15:0] di,
                          input logic [15:0] dq);
    step(v, s, di, dq, ref_mix(s, di), ref_mix(s, dq));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 16'h0, 16'h0, 16'h0, 24'h0, 24'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    signal_in = '0;
    dds_i     = '0;
    dds_q     = '0;
    model_reset();

    // reset / zero: outputs stay 0 while reset is held with valid zero inputs
    #2;
    check_zero("rst_async");
    repeat (3) begin
      @(posedge clk);
      #1;
      check_zero("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1;
    // first valid result appears after the third edge
    for (int k = 0; k < 4; k++) step(1'b1, 16'h0, 16'h0, 16'h0, 24'h0, 24'h0);
    idle(3);

    // half scale, latency is enforced cycle-exactly by the expected stream
    step(1'b1, 16'h4000, 16'h4000, 16'hC000, 24'h200000, 24'hE00000);
    idle(3);

    // extremes, back to back
    step(1'b1, 16'h7FFF, 16'h7FFF, 16'h8000, 24'h7FFE00, 24'h800100);
    step(1'b1, 16'h8000, 16'h7FFF, 16'h8000, 24'h800100, 24'h7FFFFF);
    step(1'b1, 16'h8000, 16'h8000, 16'h7FFF, 24'h7FFFFF, 24'h800100);
    idle(1);
    // rounding boundaries, with a gap so the held value is checked
    step(1'b1, 16'h0001, 16'h0040, 16'h003F, 24'h000001, 24'h000000);
    idle(2);
    step(1'b1, 16'h0001, 16'hFFC0, 16'hFFBF, 24'h000000, 24'hFFFFFF);
    step(1'b1, 16'h0001, 16'h0041, 16'hFFFF, 24'h000001, 24'h000000);
    // zero on either operand
    step(1'b1, 16'h0000, 16'h7FFF, 16'h8000, 24'h000000, 24'h000000);
    step(1'b1, 16'h8000, 16'h0000, 16'h0000, 24'h000000, 24'h000000);
    // invalid input with nonzero data must not disturb the held outputs
    step(1'b0, 16'h1234, 16'h5678, 16'h9ABC, 24'h000000, 24'h000000);
    idle(3);

    // random stream with in_valid toggling
    for (int k = 0; k < 40; k++)
      step_ref(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
               16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));

    // async reset mid-stream with valid samples in flight
    for (int k = 0; k < 3; k++)
      step_ref(1'b1, 16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)),
               16'($urandom_range(1, 65535)));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check_zero("rst_mid_edge");
    rst_n = 1'b1;
    model_reset();
    idle(3);
    for (int k = 0; k < 12; k++)
      step_ref(1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)),
               16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
    idle(3);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_mixer.md
Name: quad_mixer

Overview:
- Digital quadrature down-mixer in the NMR receive path.
- Multiplies the sampled receive signal by the in-phase and quadrature DDS local-oscillator samples to produce I and Q baseband products.
- Outputs feed the downstream decimation/filter chain.
- Fully pipelined: accepts one sample per clock, with a fixed latency of 3 clocks.

Parameters:
- IN_W, 16, width of signal_in, dds_i and dds_q (signed two's complement, Q1.(IN_W-1)).
- OUT_W, 24, width of mixed_signal_i/q (signed two's complement); must satisfy OUT_W <= 2*IN_W-1.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies signal_in/dds_i/dds_q on this clock.
- signal_in  input  IN_W  signed receive (ADC) sample.
- dds_i  input  IN_W  signed DDS cosine sample.
- dds_q  input  IN_W  signed DDS sine sample.
- mixed_signal_i  output  OUT_W  signed I product: signal_in*dds_i, scaled.
- mixed_signal_q  output  OUT_W  signed Q product: signal_in*dds_q, scaled.
- out_valid  output  1  high when mixed_signal_i/q carry a new result.

Behaviour:
- Reset:
  - rst_n low clears all pipeline registers, mixed_signal_i, mixed_signal_q and out_valid to 0 immediately, without waiting for a clock edge.
  - Release is synchronous to clk: the first input can be captured on the first rising edge after rst_n goes high.
- Pipeline, 3 stages:
  - S1 registers the inputs and in_valid.
  - S2 registers the full-precision signed products (2*IN_W bits each).
  - S3 registers the rounded and saturated outputs and out_valid.
  - An input captured on edge N appears on the outputs after edge N+2, i.e. it is valid during cycle N+3.
- No stall or backpressure; in_valid simply propagates alongside the data.
- Data registers load only when their stage valid is high. When in_valid is low, the outputs hold their previous values and out_valid goes low.
- Arithmetic for both I and Q, applied identically and independently (the same signal_in sample is used for both):
  - p = signed(signal_in) * signed(dds_x), giving 2*IN_W bits (32 bits at the defaults).
  - SH = 2*IN_W-1-OUT_W; SH = 7 at the defaults.
  - Round half-up: r = (p + 2^(SH-1)) >>> SH, with an arithmetic shift and no wrap in the addition (use 2*IN_W+1 bits).
  - Saturate r to the signed OUT_W range. Only (-2^(IN_W-1)) * (-2^(IN_W-1)) can exceed it; that case yields +2^(OUT_W-1)-1 (0x7FFFFF).
  - Negative saturation is unreachable but must still be implemented as a clamp to -2^(OUT_W-1).
- Zero on either operand gives an output of exactly 0.
- Reset asserted mid-stream discards all in-flight samples; out_valid stays low until 3 clocks after the next valid input.

Test Plan:
- Reset/zero: hold rst_n low, then release with all inputs 0 and in_valid=1 -> outputs 0 during reset and after; out_valid rises 3 clocks after the first valid input.
- Half scale, with latency checked to the cycle: signal_in=0x4000, dds_i=0x4000, dds_q=0xC000 -> mixed_signal_i=0x200000, mixed_signal_q=0xE00000, out_valid=1 exactly 3 clocks later.
- Extremes:
  - 0x7FFF*0x7FFF -> 0x7FFE00.
  - 0x8000*0x7FFF -> 0x800100.
  - 0x8000*0x8000 -> saturated 0x7FFFFF.
- Rounding: signal_in=1 with dds_i=64 -> 1; dds_i=63 -> 0; dds_i=-64 (0xFFC0) -> 0; dds_i=-65 -> 0xFFFFFF.
- Streaming/valid gaps:
  - Back-to-back random samples with in_valid toggling -> each output matches the reference model 3 clocks later.
  - Outputs hold their values and out_valid=0 in the gap cycles.
- Async reset mid-stream: assert rst_n between clock edges while data is in flight -> outputs and out_valid go to 0 immediately, and no stale results appear after release.
